// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Receiver for an 8-digit multiplexed seven-segment scan bus.
//            Each scanned digit is debounced, its active-low segment pattern
//            is decoded back to a hex nibble, and the 8 nibbles are assembled
//            into a 32-bit word published with a one-cycle frame_valid pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   STABLE_CYCLES  : consecutive samples sel/seg must hold before a digit is
//                    accepted (2..255)
//   TIMEOUT_CYCLES : cycles without an accepted digit before a partial frame
//                    is discarded (16..2^20-1)
// Ports
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-low reset
//   seg_in      in   8   observed segments, active-low, bit0=a..bit6=g, bit7=dp
//   sel_in      in   8   observed digit select, active-low one-hot
//   value_out   out  32  last error-free frame, digit i -> value_out[4i+3:4i]
//   frame_valid out  1   pulse: value_out just updated
//   frame_err   out  1   pulse: completed frame held an undecodable digit
//   timeout     out  1   pulse: partial frame discarded
//   dp_out      out  8   decimal-point bit per digit
// Build option
//   SEG_DP_CAPTURE_EN : when defined, seg[7] is captured per digit and
//                       published on dp_out; otherwise dp_out is 0 and seg[7]
//                       is ignored entirely.
// ============================================================================
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  sel_in,
  output logic [31:0] value_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        timeout,
  output logic [7:0]  dp_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    LATCHED = 2'd2
  } state_t;

`ifdef SEG_DP_CAPTURE_EN
  localparam logic [7:0] SEG_CMP_MASK = 8'hFF;
`else
  // dp bit excluded so a flickering decimal point cannot stall acceptance
  localparam logic [7:0] SEG_CMP_MASK = 8'h7F;
`endif
  localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]  STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [19:0] TO_LAST   = 20'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  sel_r, seg_r;
  logic [7:0]  cand_sel, cand_seg;
  logic [7:0]  stab_cnt, stab_next;
  logic        load_cand, accept;
  logic [7:0]  sel_low;
  logic        sel_valid;
  logic [2:0]  sel_idx;
  logic        in_changed;
  logic [3:0]  dec_nib;
  logic        dec_ok;
  logic [31:0] shadow;
  logic [7:0]  mask;
  logic        err_flag;
  logic [19:0] to_cnt;
  logic        complete;

  // One-cycle input register; everything downstream uses only these copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_r <= 8'hFF;
      seg_r <= 8'hFF;
    end else begin
      sel_r <= sel_in;
      seg_r <= seg_in;
    end
  end

  // Exactly one low select bit is a valid selection; x & (x-1) clears the
  // lowest set bit, so a zero result means at most one bit was set.
  always_comb begin
    sel_low   = ~sel_r;
    sel_valid = (sel_low != 8'h00) && ((sel_low & (sel_low - 8'd1)) == 8'h00);
    sel_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_low[i]) sel_idx = 3'(i);
    end
  end

  // Active-low hex segment table.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (seg_r[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Candidate registers hold the sample being debounced, so comparing the
  // current sample against them is the same as comparing to last cycle.
  always_comb begin
    in_changed = (sel_r != cand_sel) || (((seg_r ^ cand_seg) & SEG_CMP_MASK) != 8'h00);
    state_next = state;
    stab_next  = stab_cnt;
    load_cand  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_next = SETTLE;
          stab_next  = 8'd1;
          load_cand  = 1'b1;
        end
      end
      SETTLE, LATCHED: begin
        if (in_changed) begin
          load_cand  = 1'b1;
          state_next = sel_valid ? SETTLE : IDLE;
          stab_next  = sel_valid ? 8'd1 : 8'd0;
        end else if (state == SETTLE) begin
          if (stab_cnt == STAB_LAST) begin
            accept     = 1'b1;
            state_next = LATCHED;
            stab_next  = STAB_MAX;
          end else begin
            stab_next = stab_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        stab_next  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      stab_cnt <= 8'd0;
      cand_sel <= 8'hFF;
      cand_seg <= 8'hFF;
    end else begin
      state    <= state_next;
      stab_cnt <= stab_next;
      if (load_cand) begin
        cand_sel <= sel_r;
        cand_seg <= seg_r;
      end
    end
  end

  // Completion is evaluated the cycle after the mask fills; an accept can
  // never coincide with it because the FSM sits in LATCHED/SETTLE then.
  assign complete = !accept && (mask == 8'hFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow      <= 32'h0;
      mask        <= 8'h00;
      err_flag    <= 1'b0;
      to_cnt      <= 20'd0;
      value_out   <= 32'h0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
      if (accept) begin
        // Accept takes priority over a timeout landing in the same cycle.
        mask                       <= mask | (8'd1 << sel_idx);
        shadow[{sel_idx, 2'b00} +: 4] <= dec_ok ? dec_nib : 4'h0;
        if (!dec_ok) err_flag <= 1'b1;
        to_cnt <= 20'd0;
      end else if (complete) begin
        if (err_flag) begin
          frame_err <= 1'b1;
        end else begin
          value_out   <= shadow;
          frame_valid <= 1'b1;
        end
        mask     <= 8'h00;
        err_flag <= 1'b0;
        to_cnt   <= 20'd0;
      end else if (mask != 8'h00) begin
        if (to_cnt == TO_LAST) begin
          mask     <= 8'h00;
          err_flag <= 1'b0;
          to_cnt   <= 20'd0;
          timeout  <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 20'd1;
        end
      end
    end
  end

`ifdef SEG_DP_CAPTURE_EN
  logic [7:0] shadow_dp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_dp <= 8'h00;
      dp_out    <= 8'h00;
    end else begin
      if (accept) shadow_dp[sel_idx] <= ~seg_r[7];
      if (complete && !err_flag) dp_out <= shadow_dp;
    end
  end
`else
  assign dp_out = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Directed self-checking bench for seg_scan_decoder
//            (STABLE_CYCLES=4, TIMEOUT_CYCLES=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  seg_in;
  logic [7:0]  sel_in;
  logic [31:0] value_out;
  logic        frame_valid;
  logic        frame_err;
  logic        timeout;
  logic [7:0]  dp_out;

  int vectors     = 0;
  int miscompares = 0;
  int fv_cnt      = 0;
  int er_cnt      = 0;
  int to_cnt      = 0;
  int excl_viol   = 0;
  logic prev_pulse = 1'b0;

  seg_scan_decoder #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .sel_in     (sel_in),
    .value_out  (value_out),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .timeout    (timeout),
    .dp_out     (dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and exclusivity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_err) er_cnt++;
    if (timeout) to_cnt++;
    if ((int'(frame_valid) + int'(frame_err) + int'(timeout)) > 1) excl_viol++;
    if ((frame_valid | frame_err | timeout) && prev_pulse) excl_viol++;
    prev_pulse = frame_valid | frame_err | timeout;
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40;  4'h1: enc = 7'h79;  4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
      4'h4: enc = 7'h19;  4'h5: enc = 7'h12;  4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
      4'h8: enc = 7'h00;  4'h9: enc = 7'h10;  4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
      4'hC: enc = 7'h46;  4'hD: enc = 7'h21;  4'hE: enc = 7'h06;  default: enc = 7'h0E;
    endcase
  endfunction

  // Present digit d (d<0: no selection) for 'cycles' rising edges.
  task automatic drive(input int d, input logic [7:0] seg, input int cycles);
    @(negedge clk);
    sel_in = (d < 0) ? 8'hFF : ~(8'd1 << d);
    seg_in = seg;
    repeat (cycles - 1) @(negedge clk);
  endtask

  function automatic logic [7:0] dig_seg(input logic [31:0] val, input int d, input logic [7:0] dp);
    logic [3:0] nib;
    nib = val[4*d +: 4];
    dig_seg = {~dp[d], enc(nib)};
  endfunction

  // Scan digits [first..last] of val; digit 'blank' shows all segments off.
  task automatic scan(input logic [31:0] val, input logic [7:0] dp, input int hold,
                      input int first, input int last, input int blank);
    for (int d = first; d <= last; d++) begin
      drive(d, (d == blank) ? 8'hFF : dig_seg(val, d, dp), hold);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; sel_in = 8'hFF; seg_in = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (value_out !== 32'h0) begin miscompares++; $display("FAIL reset_value got=%h exp=%h", value_out, 32'h0); end
    vectors++; if (dp_out !== 8'h00) begin miscompares++; $display("FAIL reset_dp got=%h exp=%h", dp_out, 8'h00); end
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_to got=%b exp=0", timeout); end
  endtask

  task automatic test_full_frame;
    int fv0, er0;
    fv0 = fv_cnt; er0 = er_cnt;
    scan(32'h1234ABCD, 8'h00, 20, 0, 7, -1);
    drive(-1, 8'hFF, 6);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL full_fv_count got=%0d exp=1", fv_cnt - fv0); end
    vectors++; if (er_cnt - er0 !== 0) begin miscompares++; $display("FAIL full_err_count got=%0d exp=0", er_cnt - er0); end
    vectors++; if (value_out !== 32'h1234ABCD) begin miscompares++; $display("FAIL full_value got=%h exp=%h", value_out, 32'h1234ABCD); end
  endtask

  task automatic test_frame_err;
    int fv0, er0;
    fv0 = fv_cnt; er0 = er_cnt;
    scan(32'h55555555, 8'h00, 20, 0, 7, 2);
    drive(-1, 8'hFF, 6);
    vectors++; if (er_cnt - er0 !== 1) begin miscompares++; $display("FAIL err_pulse got=%0d exp=1", er_cnt - er0); end
    vectors++; if (fv_cnt - fv0 !== 0) begin miscompares++; $display("FAIL err_no_fv got=%0d exp=0", fv_cnt - fv0); end
    vectors++; if (value_out !== 32'h1234ABCD) begin miscompares++; $display("FAIL err_value_held got=%h exp=%h", value_out, 32'h1234ABCD); end
    fv0 = fv_cnt;
    scan(32'h00000000, 8'h00, 20, 0, 7, -1);
    drive(-1, 8'hFF, 6);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL err_recover_fv got=%0d exp=1", fv_cnt - fv0); end
    vectors++; if (value_out !== 32'h0) begin miscompares++; $display("FAIL err_recover_value got=%h exp=%h", value_out, 32'h0); end
  endtask

  task automatic test_glitch;
    int fv0;
    fv0 = fv_cnt;
    scan(32'h1234ABCD, 8'h00, 20, 0, 2, -1);
    drive(5, {1'b1, enc(4'hA)}, 2);
    scan(32'h1234ABCD, 8'h00, 20, 3, 7, -1);
    drive(-1, 8'hFF, 6);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL glitch_fv got=%0d exp=1", fv_cnt - fv0); end
    vectors++; if (value_out !== 32'h1234ABCD) begin miscompares++; $display("FAIL glitch_value got=%h exp=%h", value_out, 32'h1234ABCD); end
    // A 3-sample flash on the last digit is one short of acceptance.
    fv0 = fv_cnt;
    scan(32'h98765432, 8'h00, 8, 0, 6, -1);
    drive(7, {1'b1, enc(4'hF)}, 3);
    drive(-1, 8'hFF, 10);
    vectors++; if (fv_cnt - fv0 !== 0) begin miscompares++; $display("FAIL short_hold_rejected got=%0d exp=0", fv_cnt - fv0); end
    drive(7, {1'b1, enc(4'h9)}, 8);
    drive(-1, 8'hFF, 6);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL short_hold_then_ok got=%0d exp=1", fv_cnt - fv0); end
    vectors++; if (value_out !== 32'h98765432) begin miscompares++; $display("FAIL short_hold_value got=%h exp=%h", value_out, 32'h98765432); end
  endtask

  task automatic test_timeout;
    int fv0, to0, wait_cyc;
    bit seen;
    fv0 = fv_cnt; to0 = to_cnt; seen = 0; wait_cyc = 0;
    scan(32'hDEADBEEF, 8'h00, 20, 0, 4, -1);
    // Last accept is 4 edges into digit 4's 20-edge hold, so the pulse
    // lands 100-16 = 84 edges after idle starts: seen on the 85th negedge.
    @(negedge clk);
    sel_in = 8'hFF; seg_in = 8'hFF;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      if (timeout) begin seen = 1; wait_cyc = i; end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL timeout_seen got=0 exp=1 (no pulse in 200 cycles)"); end
    vectors++; if (wait_cyc !== 85) begin miscompares++; $display("FAIL timeout_latency got=%0d exp=85", wait_cyc); end
    vectors++; if (fv_cnt - fv0 !== 0) begin miscompares++; $display("FAIL timeout_no_fv got=%0d exp=0", fv_cnt - fv0); end
    vectors++; if (value_out !== 32'h98765432) begin miscompares++; $display("FAIL timeout_value_held got=%h exp=%h", value_out, 32'h98765432); end
    scan(32'hDEADBEEF, 8'h00, 20, 0, 7, -1);
    drive(-1, 8'hFF, 6);
    vectors++; if (to_cnt - to0 !== 1) begin miscompares++; $display("FAIL timeout_count got=%0d exp=1", to_cnt - to0); end
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL timeout_recover_fv got=%0d exp=1", fv_cnt - fv0); end
    vectors++; if (value_out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL timeout_recover_value got=%h exp=%h", value_out, 32'hDEADBEEF); end
  endtask

  task automatic test_async_reset;
    int fv0;
    scan(32'hFFFFFFFF, 8'h00, 20, 0, 3, -1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++; if (value_out !== 32'h0) begin miscompares++; $display("FAIL async_rst_value got=%h exp=%h", value_out, 32'h0); end
    vectors++; if (dp_out !== 8'h00) begin miscompares++; $display("FAIL async_rst_dp got=%h exp=%h", dp_out, 8'h00); end
    vectors++; if ({frame_valid, frame_err, timeout} !== 3'b000) begin miscompares++; $display("FAIL async_rst_pulses got=%b exp=000", {frame_valid, frame_err, timeout}); end
    sel_in = 8'hFF; seg_in = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fv0 = fv_cnt;
    scan(32'h00000042, 8'h00, 20, 0, 7, -1);
    drive(-1, 8'hFF, 6);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL post_rst_fv got=%0d exp=1", fv_cnt - fv0); end
    vectors++; if (value_out !== 32'h00000042) begin miscompares++; $display("FAIL post_rst_value got=%h exp=%h", value_out, 32'h00000042); end
  endtask

  task automatic test_back_to_back;
    int fv0;
    fv0 = fv_cnt;
    scan(32'h89ABCDEF, 8'h00, 4, 0, 7, -1);
    drive(-1, 8'hFF, 6);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL b2b_fv got=%0d exp=1", fv_cnt - fv0); end
    vectors++; if (value_out !== 32'h89ABCDEF) begin miscompares++; $display("FAIL b2b_value got=%h exp=%h", value_out, 32'h89ABCDEF); end
  endtask

  task automatic test_dp;
    int fv0;
    logic [7:0] dp_exp;
`ifdef SEG_DP_CAPTURE_EN
    dp_exp = 8'h81;
`else
    dp_exp = 8'h00;
`endif
    fv0 = fv_cnt;
    scan(32'h13579BDF, 8'h81, 20, 0, 7, -1);
    drive(-1, 8'hFF, 6);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL dp_fv got=%0d exp=1", fv_cnt - fv0); end
    vectors++; if (value_out !== 32'h13579BDF) begin miscompares++; $display("FAIL dp_value got=%h exp=%h", value_out, 32'h13579BDF); end
    vectors++; if (dp_out !== dp_exp) begin miscompares++; $display("FAIL dp_out got=%h exp=%h", dp_out, dp_exp); end
  endtask

  initial begin
    rst = 1'b0; sel_in = 8'hFF; seg_in = 8'hFF;
    test_reset;
    test_full_frame;
    test_frame_err;
    test_glitch;
    test_timeout;
    test_async_reset;
    test_back_to_back;
    test_dp;
    vectors++; if (excl_viol !== 0) begin miscompares++; $display("FAIL pulse_exclusive got=%0d exp=0", excl_viol); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
